// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single storage controller.
// One access outstanding at a time; illegal requests and hung accesses return an error response.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int MEM_W          = 32,
  parameter int MEM_SZ         = 262144,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic               if_err_o,
  input  logic               dm_req_i,
  input  logic               dm_we_i,
  input  logic [MEM_W/8-1:0] dm_be_i,
  input  logic [31:0]        dm_addr_i,
  input  logic [31:0]        dm_wdata_i,
  output logic               dm_gnt_o,
  output logic               dm_rvalid_o,
  output logic               dm_err_o,
  output logic [31:0]        rdata_o,
  output logic               memory_access,
  output logic               memory_is_writing,
  output logic [31:0]        addr,
  output logic [31:0]        d_in,
  output logic [MEM_W/8-1:0] mem_be,
  output logic               external_storage_access,
  input  logic [31:0]        d_out,
  input  logic               out_valid
);

  localparam int                BE_W      = MEM_W / 8;
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]       MEM_LIMIT = 33'(MEM_SZ);

  typedef enum logic [1:0] {IDLE, ACCESS, ERRRESP} state_t;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [31:0]     addr;
    logic [31:0]     wdata;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_new, req_q;
  logic             ext_q;
  logic             last_if_q;
  logic             owner_dm_q;
  logic [CNT_W-1:0] cnt_q;
  logic             if_rvalid_q, dm_rvalid_q, if_err_q, dm_err_q;
  logic [31:0]      rdata_q;

  logic pick_dm, pick_if, gnt_any;
  logic new_sram, new_ext, new_legal;
  logic in_acc, timeout;

  // Round-robin: on contention the port that did not win last time goes first.
  always_comb begin
    pick_dm = dm_req_i && (!if_req_i || last_if_q);
    pick_if = if_req_i && !pick_dm;
    gnt_any = (state == IDLE) && !rst && (pick_dm || pick_if);
  end

  assign if_gnt_o = gnt_any && pick_if;
  assign dm_gnt_o = gnt_any && pick_dm;

  always_comb begin
    req_new.we    = 1'b0;
    req_new.be    = '1;
    req_new.addr  = if_addr_i;
    req_new.wdata = '0;
    if (pick_dm) begin
      req_new.we    = dm_we_i;
      req_new.be    = dm_be_i;
      req_new.addr  = dm_addr_i;
      req_new.wdata = dm_wdata_i;
    end
  end

  // External storage is read-only; anything past MEM_SZ is unmapped.
  always_comb begin
    new_sram  = (req_new.addr[31:12] == 20'd0);
    new_ext   = !new_sram && ({1'b0, req_new.addr} < MEM_LIMIT) && !req_new.we;
    new_legal = new_sram || new_ext;
  end

  assign in_acc  = (state == ACCESS);
  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = new_legal ? ACCESS : ERRRESP;
      ACCESS:  if (out_valid || timeout) state_nxt = IDLE;
      ERRRESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      ext_q       <= 1'b0;
      last_if_q   <= 1'b1;
      owner_dm_q  <= 1'b0;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            req_q      <= req_new;
            ext_q      <= new_ext;
            owner_dm_q <= pick_dm;
            last_if_q  <= pick_if;
            cnt_q      <= '0;
            // Illegal requests answer one cycle after the grant, from ERRRESP.
            if (!new_legal) begin
              if_rvalid_q <= pick_if;
              dm_rvalid_q <= pick_dm;
              if_err_q    <= pick_if;
              dm_err_q    <= pick_dm;
              rdata_q     <= '0;
            end
          end
        end
        ACCESS: begin
          if (out_valid) begin
            if_rvalid_q <= !owner_dm_q;
            dm_rvalid_q <= owner_dm_q;
            rdata_q     <= d_out;
          end else if (timeout) begin
            if_rvalid_q <= !owner_dm_q;
            dm_rvalid_q <= owner_dm_q;
            if_err_q    <= !owner_dm_q;
            dm_err_q    <= owner_dm_q;
            rdata_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_err_o    = if_err_q;
  assign dm_err_o    = dm_err_q;
  assign rdata_o     = rdata_q;

  // Storage-side signals are only live while an access is in flight.
  assign memory_access           = in_acc;
  assign memory_is_writing       = in_acc && req_q.we;
  assign addr                    = in_acc ? req_q.addr  : '0;
  assign d_in                    = in_acc ? req_q.wdata : '0;
  assign mem_be                  = in_acc ? req_q.be    : '0;
  assign external_storage_access = in_acc && ext_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table + scoreboard, plus round-robin, timeout and reset sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, dm_req_i, dm_we_i, out_valid;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, d_out;
  logic [3:0]  dm_be_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o, dm_gnt_o, dm_rvalid_o, dm_err_o;
  logic        memory_access, memory_is_writing, external_storage_access;
  logic [31:0] rdata_o, addr, d_in;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;
  int cur   = -1;

  mem_port_arbiter #(.MEM_W(32), .MEM_SZ(262144), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_err_o(if_err_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_err_o(dm_err_o),
    .rdata_o(rdata_o), .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be), .external_storage_access(external_storage_access),
    .d_out(d_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    int          dly;
    logic [31:0] dout;
    logic        acc;
    logic        ext;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    logic        dm;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0h want %0h", name, cur, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {if_gnt_o, if_rvalid_o, if_err_o, dm_gnt_o, dm_rvalid_o, dm_err_o,
            memory_access, memory_is_writing, external_storage_access, mem_be,
            |addr, |d_in, |rdata_o};
  endfunction

  task automatic check_resp();
    exp_t e;
    int   n = 0;
    while (!(if_rvalid_o || dm_rvalid_o) && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    cmp("rsp_latency", n, 0);
    if (sb.size() == 0) begin
      cmp("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      cmp("rsp_port", {dm_rvalid_o, if_rvalid_o}, e.dm ? 2'b10 : 2'b01);
      cmp("rsp_err", e.dm ? dm_err_o : if_err_o, e.err);
      if (e.chk_rd) cmp("rsp_rdata", rdata_o, e.rdata);
      cmp("acc_off_at_rsp", {memory_access, addr}, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    if (v.dm) begin
      dm_req_i = 1; dm_we_i = v.we; dm_be_i = v.be; dm_addr_i = v.a; dm_wdata_i = v.wd;
    end else begin
      if_req_i = 1; if_addr_i = v.a;
    end
    #1;
    cmp("grant", {dm_gnt_o, if_gnt_o}, v.dm ? 2'b10 : 2'b01);
    e = '{v.dm, v.err, v.rdata, v.chk_rd};
    sb.push_back(e);
    @(negedge clk);
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
    #1;
    if (v.acc) begin
      cmp("acc_on", memory_access, 1);
      cmp("acc_addr", addr, v.a);
      cmp("acc_ext", external_storage_access, v.ext);
      cmp("acc_we", memory_is_writing, v.we);
      cmp("acc_be", mem_be, v.dm ? v.be : 4'hF);
      if (v.we) cmp("acc_wdata", d_in, v.wd);
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clk); #1;
        cmp("acc_hold", {memory_access, addr}, {1'b1, v.a});
      end
      out_valid = 1; d_out = v.dout;
      @(negedge clk);
      out_valid = 0; d_out = 0;
      #1;
    end else begin
      cmp("no_acc", {memory_access, external_storage_access}, 0);
    end
    check_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    //            dm we  addr          be    wdata         dly dout          acc ext err rdata         chk
    vecs[0]  = '{1, 0, 32'h0000_0010, 4'hF, 32'h0,        1, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF, 1};
    vecs[1]  = '{0, 0, 32'h0000_2000, 4'hF, 32'h0,        0, 32'h1234_5678, 1, 1, 0, 32'h1234_5678, 1};
    vecs[2]  = '{1, 1, 32'h0000_2000, 4'hF, 32'h1111,     0, 32'h0,        0, 0, 1, 32'h0,        1};
    vecs[3]  = '{1, 0, 32'h0004_0000, 4'hF, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0,        1};
    vecs[4]  = '{1, 1, 32'h0000_0FFC, 4'h3, 32'hA5A5_5A5A, 2, 32'h0,        1, 0, 0, 32'h0,        0};
    vecs[5]  = '{0, 0, 32'h0003_FFFC, 4'hF, 32'h0,        3, 32'hCAFE_F00D, 1, 1, 0, 32'hCAFE_F00D, 1};
    vecs[6]  = '{0, 0, 32'h0000_1000, 4'hF, 32'h0,        0, 32'h0000_1111, 1, 1, 0, 32'h0000_1111, 1};
    vecs[7]  = '{1, 0, 32'hFFFF_FFFC, 4'hF, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0,        1};
    vecs[8]  = '{0, 0, 32'h0000_0000, 4'hF, 32'h0,        7, 32'h8765_4321, 1, 0, 0, 32'h8765_4321, 1};
    vecs[9]  = '{1, 0, 32'h0000_0FFF, 4'h1, 32'h0,        0, 32'h5555_AAAA, 1, 0, 0, 32'h5555_AAAA, 1};
    vecs[10] = '{0, 0, 32'h0004_0000, 4'hF, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0,        1};

    rst = 1; if_req_i = 0; dm_req_i = 1; dm_we_i = 0; dm_be_i = 0; if_addr_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0; out_valid = 0; d_out = 0;
    #12;
    cmp("reset_outputs", all_outs(), 0);
    dm_req_i = 0;
    @(negedge clk);
    rst = 0;

    // Both ports held high: DM first after reset, then alternate; each grant lands with the previous rvalid.
    if_addr_i = 32'h100; dm_addr_i = 32'h104; dm_be_i = 4'hF; dm_we_i = 0;
    if_req_i = 1; dm_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp("rr_grant", {dm_gnt_o, if_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) begin
        cmp("rr_rvalid_with_grant", {dm_rvalid_o, if_rvalid_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
        cmp("rr_rdata", rdata_o, i - 1);
      end
      @(negedge clk);
      if (i == 3) begin if_req_i = 0; dm_req_i = 0; end
      out_valid = 1; d_out = i;
      @(negedge clk);
      out_valid = 0;
    end
    #1;
    cmp("rr_last_rvalid", {dm_rvalid_o, if_rvalid_o}, 2'b01);

    for (int i = 0; i < 11; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end
    cur = -1;

    // Timeout: memory_access for exactly 8 cycles, then err pulse; late out_valid ignored.
    @(negedge clk);
    dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h20;
    #1;
    cmp("to_grant", dm_gnt_o, 1);
    @(negedge clk);
    dm_req_i = 0;
    #1;
    n = 0;
    while (memory_access && n < 30) begin
      n++;
      @(negedge clk); #1;
    end
    cmp("to_acc_cycles", n, 8);
    cmp("to_rsp", {dm_rvalid_o, dm_err_o, if_rvalid_o}, 3'b110);
    cmp("to_rdata", rdata_o, 0);
    out_valid = 1; d_out = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    cmp("late_ov_ignored", {dm_rvalid_o, if_rvalid_o, memory_access, rdata_o}, 0);
    @(negedge clk);
    out_valid = 0;
    #1;
    cmp("late_ov_ignored2", {dm_rvalid_o, if_rvalid_o, memory_access, rdata_o}, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    dm_req_i = 1; dm_addr_i = 32'h30;
    @(negedge clk);
    dm_req_i = 0;
    #1;
    cmp("mid_acc_on", memory_access, 1);
    #2 rst = 1;
    #1;
    cmp("mid_reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 0;
    cur = 100;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_W, default 32, meaning memory bus width in bits.
REQ-002 SHALL have parameter MEM_SZ, default 262144, meaning external storage size in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles an access may wait for out_valid.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port if_req_i, input, 1, instruction fetch read request.
REQ-007 SHALL have port if_addr_i, input, 32, instruction fetch byte address.
REQ-008 SHALL have port if_gnt_o, output, 1, instruction fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid_o, output, 1, instruction fetch response valid (one-cycle pulse).
REQ-010 SHALL have port if_err_o, output, 1, instruction fetch response is an error; qualified by if_rvalid_o.
REQ-011 SHALL have port dm_req_i, input, 1, data request.
REQ-012 SHALL have port dm_we_i, input, 1, data request is a write.
REQ-013 SHALL have port dm_be_i, input, MEM_W/8, data byte enables.
REQ-014 SHALL have port dm_addr_i, input, 32, data byte address.
REQ-015 SHALL have port dm_wdata_i, input, 32, data write data.
REQ-016 SHALL have port dm_gnt_o, output, 1, data request accepted this cycle.
REQ-017 SHALL have port dm_rvalid_o, output, 1, data response valid (one-cycle pulse).
REQ-018 SHALL have port dm_err_o, output, 1, data response is an error; qualified by dm_rvalid_o.
REQ-019 SHALL have port rdata_o, output, 32, response data shared by both ports.
REQ-020 SHALL have port memory_access, output, 1, request to the storage controller.
REQ-021 SHALL have port memory_is_writing, output, 1, storage access is a write.
REQ-022 SHALL have port addr, output, 32, storage byte address.
REQ-023 SHALL have port d_in, output, 32, storage write data.
REQ-024 SHALL have port mem_be, output, MEM_W/8, storage byte enables.
REQ-025 SHALL have port external_storage_access, output, 1, selects QSPI storage rather than SRAM.
REQ-026 SHALL have port d_out, input, 32, storage read data.
REQ-027 SHALL have port out_valid, input, 1, storage access complete (one-cycle pulse).

Function
REQ-028 SHALL implement the FSM states IDLE, ACCESS and ERRRESP, with at most one request outstanding.
REQ-029 SHALL assert a grant in IDLE only, combinationally in the same cycle as the request, and SHALL capture the granted request's addr, we, be and wdata in registers on that edge.
REQ-030 SHALL arbitrate simultaneous if_req_i and dm_req_i round-robin on the last grant; after reset the data port wins first.
REQ-031 SHALL treat an IF request as a read with all byte enables set.
REQ-032 SHALL classify a captured request as follows: addr[31:12]==0 is SRAM (external_storage_access=0); otherwise addr < MEM_SZ and read is external (external_storage_access=1); otherwise illegal.
REQ-033 SHALL make a write to the external region an illegal request.
REQ-034 SHALL, on a legal grant, go IDLE->ACCESS and drive memory_access=1 together with the captured fields, held stable until the out_valid cycle inclusive.
REQ-035 SHALL, on out_valid in ACCESS, register d_out into rdata_o, go to IDLE, and pulse the owner's rvalid for one cycle on the next cycle with err=0.
REQ-036 SHALL, for a write, still return an rvalid pulse and SHALL leave rdata_o unspecified.
REQ-037 SHALL, on an illegal grant, go IDLE->ERRRESP with no memory_access, and in the next cycle pulse rvalid+err with rdata_o=0 and return to IDLE.
REQ-038 SHALL count cycles in ACCESS; at TIMEOUT_CYCLES without out_valid it SHALL drop memory_access, pulse rvalid+err with rdata_o=0 the next cycle, and go to IDLE.
REQ-039 SHALL give out_valid priority over timeout when both occur in the same cycle.
REQ-040 SHALL allow a new grant in the same cycle as an rvalid pulse.
REQ-041 SHALL ignore out_valid outside ACCESS.
REQ-042 SHALL keep memory_access, memory_is_writing, addr, d_in and mem_be at 0 whenever not in ACCESS.

Reset
REQ-043 SHALL, on rst, force asynchronously: FSM=IDLE, all outputs 0, timeout counter 0, last-grant=IF.

Verification
REQ-044 SHALL pass: dm read of 0x0000_0010 granted at cycle T, with out_valid at T+2 and d_out=0xDEADBEEF -> memory_access during T+1..T+2, dm_rvalid_o at T+3, rdata_o=0xDEADBEEF, err=0.
REQ-045 SHALL pass: if_req_i and dm_req_i held high for 4 transactions -> grants alternate DM, IF, DM, IF.
REQ-046 SHALL pass: IF read of 0x0000_2000 -> external_storage_access=1, addr=0x0000_2000; a dm write to 0x0000_2000 -> no memory_access, dm_rvalid_o+dm_err_o one cycle after the grant.
REQ-047 SHALL pass: read of 0x0004_0000 -> error response, rdata_o=0.
REQ-048 SHALL pass: with TIMEOUT_CYCLES=8 and out_valid never asserted -> memory_access deasserts after 8 cycles, err pulse follows; a late out_valid is then ignored.
REQ-049 SHALL pass: rst asserted mid-ACCESS -> all outputs 0 immediately; the first request after release is accepted normally.
